morse_decoder: RTL and testbench
================================

// Module: morse_decoder
// PURPOSE
//  Receive-side counterpart of morse_generator. Samples a hand-keyed morse line, times marks and gaps
//  in units of MORSE_CYCLES and classifies them as dot/dash/letter-gap/word-gap. Looks up each completed
//  letter and emits one ASCII byte (A-Z, 0-9, word space 0x20) as a 1-cycle strobe for uart_echo TX / display.
// PARAMETERS
//  MORSE_CYCLES     20_000_000  clk cycles per morse unit (200ms @100MHz); must match morse_generator
//  DEBOUNCE_CYCLES  1_000_000   cycles morse_i must hold a new level before acceptance (10ms)
//  MAX_SYMBOLS      5           max dots/dashes per letter; one more flags overflow
// PORTS
//  clk_i      in   1  clock (100MHz)
//  reset_i    in   1  reset, asynchronous, active-low
//  morse_i    in   1  raw key line, asynchronous to clk_i, 1 = key down (mark)
//  ascii_o    out  8  decoded character, held until next strobe
//  valid_o    out  1  1-cycle strobe: ascii_o updated this cycle
//  error_o    out  1  1-cycle strobe: letter unrecognised or overflowed; ascii_o unchanged
//  busy_o     out  1  1 while a letter is being keyed (symbols pending or key down)
// BEHAVIOUR
//  - Reset (reset_i=0): ascii_o=8'h00, valid_o=0, error_o=0, busy_o=0; FSM IDLE; all counters/shift reg cleared.
//  - Input: 2-FF synchroniser, then debouncer; key = debounced level. Input-to-key latency DEBOUNCE_CYCLES+2.
//    Pulses shorter than DEBOUNCE_CYCLES never change key.
//  - Timing: cycle counter wraps at MORSE_CYCLES-1 and increments unit counter (3 bits, saturates at 7).
//    Both clear on every key edge.
//  - FSM states IDLE, MARK, GAP, LETTER_DONE:
//    IDLE: key rise -> MARK. Nothing emitted.
//    MARK: on key fall: units<2 -> dot, units>=2 -> dash (saturated, any long mark is dash).
//      Shift symbol into pattern reg (shift left, new bit in LSB, 1=dash), len++ -> GAP.
//      If len was already MAX_SYMBOLS, set overflow flag instead of shifting.
//    GAP: key rise with units<2 -> MARK (same letter). units reaches 2 -> emit letter -> LETTER_DONE.
//    LETTER_DONE: key rise before units=5 -> MARK (new letter, no space). units reaches 5 -> emit 0x20 -> IDLE.
//  - Emit letter: registered, strobe asserted the cycle after the threshold match.
//    Overflow or no table match -> error_o=1. Otherwise ascii_o=lookup, valid_o=1.
//    Then clear pattern, len, overflow; busy_o falls the same cycle as the strobe.
//  - Word space: one 0x20 per idle gap. Emitted only if the preceding letter emitted valid_o (not error_o).
//    Never two spaces back to back.
//  - Simultaneous: key rise in the same cycle as a gap threshold. Threshold action wins (letter/space emitted),
//    then the FSM enters MARK directly. No symbol lost.
//  - valid_o and error_o are never high together. Strobes are at least MORSE_CYCLES apart.
//  - Reset mid-letter discards pending symbols without any strobe.
// STRUCTURE
//  - morse_defs.vh (shared with morse_generator):
//    unit thresholds DASH_UNITS=2, LETTER_GAP_UNITS=2, WORD_GAP_UNITS=5, ASCII_SPACE=8'h20.
//    function morse_lookup(len[2:0], pattern[4:0]) -> {hit, ascii[7:0]}; generator uses the inverse table.
//  - Sub-module morse_debouncer (sync + debounce, params DEBOUNCE_CYCLES, ports clk_i/reset_i/d_i/q_o).
//  - Top-level wiring: morse_i from a PMOD/button pin; ascii_o/valid_o optionally into the UART TX FIFO write port.
// TESTING  (bench: MORSE_CYCLES=10, DEBOUNCE_CYCLES=2)
//  - Key 'E': mark 10cy, release 80cy -> valid_o with ascii_o=0x45 ~20cy after release,
//    then valid_o with 0x20 ~30cy later, busy_o 0.
//  - Key 'A': mark 10, gap 10, mark 30, release -> single valid_o, ascii_o=0x41. No error_o.
//  - Key '0': five 30cy marks separated by 10cy gaps -> ascii_o=0x30.
//    Key six dots -> error_o once, ascii_o unchanged, no following space.
//  - Glitch: 1-cycle and 2-cycle pulses on morse_i with key idle -> no state change, busy_o stays 0, no strobes.
//  - "ET" with 30cy letter gap -> 0x45, 0x54, no space between. Then 60cy idle -> exactly one 0x20.
//  - Reset: drop reset_i mid-dash of 'T' -> outputs zero immediately. Release and idle 100cy -> no strobes.
//    Next 'T' decodes to 0x54.

Source files
------------

// File: rtl/morse_decoder_pkg.sv
// Shared morse timing thresholds, FSM state type and the letter lookup table.
// Pattern encoding: first keyed symbol in the MSB of the valid bits, 1 = dash.
package morse_decoder_pkg;

    localparam int UNIT_W = 3;
    localparam int PAT_W  = 5;

    localparam logic [UNIT_W-1:0] DASH_UNITS       = 3'd2;
    localparam logic [UNIT_W-1:0] LETTER_GAP_UNITS = 3'd2;
    localparam logic [UNIT_W-1:0] WORD_GAP_UNITS   = 3'd5;
    localparam logic [7:0]        ASCII_SPACE      = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        GAP,
        LETTER_DONE
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [7:0] ascii;
    } lookup_t;

    function automatic lookup_t morse_lookup(input logic [2:0] len, input logic [PAT_W-1:0] pattern);
        lookup_t r;
        r.hit   = 1'b1;
        r.ascii = 8'h00;
        case ({len, pattern})
            {3'd2, 5'b00001}: r.ascii = "A";
            {3'd4, 5'b01000}: r.ascii = "B";
            {3'd4, 5'b01010}: r.ascii = "C";
            {3'd3, 5'b00100}: r.ascii = "D";
            {3'd1, 5'b00000}: r.ascii = "E";
            {3'd4, 5'b00010}: r.ascii = "F";
            {3'd3, 5'b00110}: r.ascii = "G";
            {3'd4, 5'b00000}: r.ascii = "H";
            {3'd2, 5'b00000}: r.ascii = "I";
            {3'd4, 5'b00111}: r.ascii = "J";
            {3'd3, 5'b00101}: r.ascii = "K";
            {3'd4, 5'b00100}: r.ascii = "L";
            {3'd2, 5'b00011}: r.ascii = "M";
            {3'd2, 5'b00010}: r.ascii = "N";
            {3'd3, 5'b00111}: r.ascii = "O";
            {3'd4, 5'b00110}: r.ascii = "P";
            {3'd4, 5'b01101}: r.ascii = "Q";
            {3'd3, 5'b00010}: r.ascii = "R";
            {3'd3, 5'b00000}: r.ascii = "S";
            {3'd1, 5'b00001}: r.ascii = "T";
            {3'd3, 5'b00001}: r.ascii = "U";
            {3'd4, 5'b00001}: r.ascii = "V";
            {3'd3, 5'b00011}: r.ascii = "W";
            {3'd4, 5'b01001}: r.ascii = "X";
            {3'd4, 5'b01011}: r.ascii = "Y";
            {3'd4, 5'b01100}: r.ascii = "Z";
            {3'd5, 5'b11111}: r.ascii = "0";
            {3'd5, 5'b01111}: r.ascii = "1";
            {3'd5, 5'b00111}: r.ascii = "2";
            {3'd5, 5'b00011}: r.ascii = "3";
            {3'd5, 5'b00001}: r.ascii = "4";
            {3'd5, 5'b00000}: r.ascii = "5";
            {3'd5, 5'b10000}: r.ascii = "6";
            {3'd5, 5'b11000}: r.ascii = "7";
            {3'd5, 5'b11100}: r.ascii = "8";
            {3'd5, 5'b11110}: r.ascii = "9";
            default:          r.hit   = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morse_decoder_debouncer.sv
// Two-flop synchroniser plus level debouncer; key changes DEBOUNCE_CYCLES+3 edges after input.
// Latency: fixed; no backpressure (free-running level filter).
module morse_decoder_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] stable_cnt;

    // A new level must be seen on more than DEBOUNCE_CYCLES consecutive edges,
    // so a pulse of exactly DEBOUNCE_CYCLES is still rejected.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            q_o        <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_q1 <= d_i;
            sync_q2 <= sync_q1;
            if (sync_q2 == q_o) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                q_o        <= sync_q2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: times debounced marks/gaps in units, decodes letters, strobes ASCII (A-Z, 0-9, space).
// Latency: letter strobe one cycle after the letter-gap threshold; no backpressure, strobes are fire-and-forget.
module morse_decoder
    import morse_decoder_pkg::*;
#(
    parameter int MORSE_CYCLES    = 20_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_SYMBOLS     = 5
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       morse_i,
    output logic [7:0] ascii_o,
    output logic       valid_o,
    output logic       error_o,
    output logic       busy_o
);

    localparam int               CYC_W   = (MORSE_CYCLES > 1) ? $clog2(MORSE_CYCLES) : 1;
    localparam logic [2:0]       MAX_LEN = 3'(MAX_SYMBOLS);

    logic              key;
    logic              key_q;
    logic              key_rise;
    logic              key_fall;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [UNIT_W-1:0] units;
    state_t            state;
    state_t            state_nxt;
    logic              do_shift;
    logic              do_letter;
    logic              do_space;
    logic              is_dash;
    logic [PAT_W-1:0]  pattern;
    logic [2:0]        len;
    logic              overflow;
    logic              last_valid;
    lookup_t           lk;

    morse_decoder_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .d_i    (morse_i),
        .q_o    (key)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            key_q <= 1'b0;
        end else begin
            key_q <= key;
        end
    end

    assign key_rise = key & ~key_q;
    assign key_fall = ~key & key_q;

    // Unit timer restarts on every key edge so units always measure the current mark or gap.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cyc_cnt <= '0;
            units   <= '0;
        end else if (key_rise || key_fall) begin
            cyc_cnt <= '0;
            units   <= '0;
        end else if (cyc_cnt == CYC_W'(MORSE_CYCLES - 1)) begin
            cyc_cnt <= '0;
            if (units != '1) begin
                units <= units + 3'd1;
            end
        end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Gap thresholds take priority over a simultaneous key rise; the rise still lands in MARK.
    always_comb begin
        state_nxt = state;
        do_shift  = 1'b0;
        do_letter = 1'b0;
        do_space  = 1'b0;
        case (state)
            IDLE: begin
                if (key_rise) state_nxt = MARK;
            end
            MARK: begin
                if (key_fall) begin
                    do_shift  = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (units >= LETTER_GAP_UNITS) begin
                    do_letter = 1'b1;
                    state_nxt = key_rise ? MARK : LETTER_DONE;
                end else if (key_rise) begin
                    state_nxt = MARK;
                end
            end
            LETTER_DONE: begin
                if (units >= WORD_GAP_UNITS) begin
                    do_space  = last_valid;
                    state_nxt = key_rise ? MARK : IDLE;
                end else if (key_rise) begin
                    state_nxt = MARK;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign is_dash = (units >= DASH_UNITS);
    assign lk      = morse_lookup(len, pattern);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pattern    <= '0;
            len        <= '0;
            overflow   <= 1'b0;
            last_valid <= 1'b0;
            ascii_o    <= 8'h00;
            valid_o    <= 1'b0;
            error_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            error_o <= 1'b0;
            if (do_shift) begin
                if (len == MAX_LEN) begin
                    overflow <= 1'b1;
                end else begin
                    pattern <= {pattern[PAT_W-2:0], is_dash};
                    len     <= len + 3'd1;
                end
            end
            if (do_letter) begin
                if (overflow || !lk.hit) begin
                    error_o    <= 1'b1;
                    last_valid <= 1'b0;
                end else begin
                    ascii_o    <= lk.ascii;
                    valid_o    <= 1'b1;
                    last_valid <= 1'b1;
                end
                pattern  <= '0;
                len      <= '0;
                overflow <= 1'b0;
            end
            // Clearing last_valid guarantees a single space per idle gap.
            if (do_space) begin
                ascii_o    <= ASCII_SPACE;
                valid_o    <= 1'b1;
                last_valid <= 1'b0;
            end
        end
    end

    assign busy_o = (state == MARK) || (state == GAP);

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder: keyed scenarios plus random letters against a table-driven model.
// Model classifies raw mark/gap durations in units and looks letters up in a string table.
module tb_morse_decoder;

    localparam int M = 10;
    localparam int D = 2;

    logic       clk_i   = 1'b0;
    logic       reset_i = 1'b0;
    logic       morse_i = 1'b0;
    logic [7:0] ascii_o;
    logic       valid_o;
    logic       error_o;
    logic       busy_o;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int last_fall = 0;

    typedef struct {
        logic       err;
        logic [7:0] ascii;
        int         rel;
        logic       both;
    } ev_t;

    typedef struct {
        logic       err;
        logic [7:0] ascii;
        logic       is_space;
    } exp_t;

    ev_t        seen[$];
    exp_t       expq[$];
    logic [7:0] model_ascii = 8'h00;
    logic       model_last_valid = 1'b0;

    string codes[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                         "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                         "..-", "...-", ".--", "-..-", "-.--", "--..",
                         "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                         "---..", "----."};

    morse_decoder #(
        .MORSE_CYCLES   (M),
        .DEBOUNCE_CYCLES(D),
        .MAX_SYMBOLS    (5)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .morse_i(morse_i),
        .ascii_o(ascii_o),
        .valid_o(valid_o),
        .error_o(error_o),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (reset_i && (valid_o || error_o))
            seen.push_back('{error_o, ascii_o, cyc - last_fall, valid_o && error_o});
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic logic [7:0] code_char(input int idx);
        return (idx < 26) ? 8'(65 + idx) : 8'(48 + idx - 26);
    endfunction

    function automatic void model_letter(input string syms, input int gap_after);
        int idx = -1;
        for (int i = 0; i < 36; i++)
            if (codes[i] == syms) idx = i;
        if (gap_after < 2 * M) return;
        if (idx < 0) begin
            expq.push_back('{1'b1, model_ascii, 1'b0});
            model_last_valid = 1'b0;
        end else begin
            model_ascii = code_char(idx);
            expq.push_back('{1'b0, model_ascii, 1'b0});
            model_last_valid = 1'b1;
        end
        if (gap_after >= 5 * M && model_last_valid) begin
            model_ascii = 8'h20;
            expq.push_back('{1'b0, 8'h20, 1'b1});
            model_last_valid = 1'b0;
        end
    endfunction

    task automatic send(input string syms, input int gap_after, input int dot_len,
                        input int dash_len, input int sym_gap);
        model_letter(syms, gap_after);
        for (int i = 0; i < syms.len(); i++) begin
            morse_i = 1'b1;
            repeat ((syms[i] == "-") ? dash_len : dot_len) @(negedge clk_i);
            morse_i   = 1'b0;
            last_fall = cyc;
            if (i < syms.len() - 1) repeat (sym_gap) @(negedge clk_i);
        end
        repeat (gap_after) @(negedge clk_i);
    endtask

    task automatic test_reset;
        @(negedge clk_i);
        checks++;
        if (ascii_o !== 8'h00 || valid_o !== 1'b0 || error_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ascii=%h valid=%b error=%b busy=%b want 00 0 0 0",
                     ascii_o, valid_o, error_o, busy_o);
        end
        reset_i = 1'b1;
        repeat (5) @(negedge clk_i);
    endtask

    task automatic test_letters;
        int lo;
        seen.delete();
        expq.delete();
        send(".", 80, 10, 30, 10);
        send(".-", 70, 10, 30, 10);
        send("-----", 70, 10, 30, 10);
        send("......", 70, 10, 30, 10);
        checks++;
        if (seen.size() != expq.size()) begin
            errors++;
            $display("FAIL letters_count: got %0d strobes want %0d", seen.size(), expq.size());
        end
        for (int i = 0; i < seen.size() && i < expq.size(); i++) begin
            checks++;
            if (seen[i].err !== expq[i].err || seen[i].ascii !== expq[i].ascii || seen[i].both) begin
                errors++;
                $display("FAIL letters_ev%0d: got err=%b ascii=%h want err=%b ascii=%h",
                         i, seen[i].err, seen[i].ascii, expq[i].err, expq[i].ascii);
            end
            lo = expq[i].is_space ? 5 * M : 2 * M;
            checks++;
            if (seen[i].rel < lo || seen[i].rel > lo + 12) begin
                errors++;
                $display("FAIL letters_time%0d: got %0d cycles after release want %0d..%0d",
                         i, seen[i].rel, lo, lo + 12);
            end
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL letters_busy: got %b want 0", busy_o);
        end
    endtask

    task automatic test_glitch;
        int busy_seen = 0;
        seen.delete();
        morse_i = 1'b1;
        @(negedge clk_i);
        morse_i = 1'b0;
        repeat (10) begin
            @(negedge clk_i);
            if (busy_o) busy_seen++;
        end
        morse_i = 1'b1;
        repeat (2) @(negedge clk_i);
        morse_i = 1'b0;
        repeat (30) begin
            @(negedge clk_i);
            if (busy_o) busy_seen++;
        end
        checks++;
        if (busy_seen != 0 || seen.size() != 0) begin
            errors++;
            $display("FAIL glitch: got busy_cycles=%0d strobes=%0d want 0 0", busy_seen, seen.size());
        end
    endtask

    task automatic test_word_gap;
        seen.delete();
        expq.delete();
        send(".", 30, 10, 30, 10);
        send("-", 60, 10, 30, 10);
        repeat (20) @(negedge clk_i);
        checks++;
        if (seen.size() != 3) begin
            errors++;
            $display("FAIL et_count: got %0d strobes want 3", seen.size());
        end
        for (int i = 0; i < seen.size() && i < expq.size(); i++) begin
            checks++;
            if (seen[i].err !== expq[i].err || seen[i].ascii !== expq[i].ascii) begin
                errors++;
                $display("FAIL et_ev%0d: got err=%b ascii=%h want err=%b ascii=%h",
                         i, seen[i].err, seen[i].ascii, expq[i].err, expq[i].ascii);
            end
        end
    endtask

    task automatic test_reset_mid_letter;
        seen.delete();
        expq.delete();
        morse_i = 1'b1;
        repeat (20) @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL midmark_busy: got %b want 1", busy_o);
        end
        #2 reset_i = 1'b0;
        #1;
        checks++;
        if (ascii_o !== 8'h00 || valid_o !== 1'b0 || error_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got ascii=%h valid=%b error=%b busy=%b want 00 0 0 0",
                     ascii_o, valid_o, error_o, busy_o);
        end
        morse_i = 1'b0;
        model_ascii      = 8'h00;
        model_last_valid = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b1;
        repeat (100) @(negedge clk_i);
        checks++;
        if (seen.size() != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got strobes=%0d busy=%b want 0 0", seen.size(), busy_o);
        end
        send("-", 70, 10, 30, 10);
        checks++;
        if (seen.size() != expq.size() || seen.size() == 0 || seen[0].ascii !== 8'h54 || seen[0].err) begin
            errors++;
            $display("FAIL post_reset_T: got %0d strobes first=%h want %0d first=54",
                     seen.size(), (seen.size() > 0) ? seen[0].ascii : 8'hxx, expq.size());
        end
    endtask

    task automatic test_random;
        int idx;
        int gap;
        int lo;
        string syms;
        seen.delete();
        expq.delete();
        for (int n = 0; n < 24; n++) begin
            idx  = $urandom_range(37, 0);
            syms = (idx >= 36) ? "......" : codes[idx];
            gap  = ($urandom_range(3, 0) == 0) ? $urandom_range(75, 60) : $urandom_range(35, 25);
            if (n == 23) gap = 70;
            send(syms, gap, $urandom_range(12, 8), $urandom_range(33, 28), $urandom_range(12, 8));
        end
        checks++;
        if (seen.size() != expq.size()) begin
            errors++;
            $display("FAIL random_count: got %0d strobes want %0d", seen.size(), expq.size());
        end
        for (int i = 0; i < seen.size() && i < expq.size(); i++) begin
            checks++;
            if (seen[i].err !== expq[i].err || seen[i].ascii !== expq[i].ascii || seen[i].both) begin
                errors++;
                $display("FAIL random_ev%0d: got err=%b ascii=%h want err=%b ascii=%h",
                         i, seen[i].err, seen[i].ascii, expq[i].err, expq[i].ascii);
            end
            lo = expq[i].is_space ? 5 * M : 2 * M;
            checks++;
            if (seen[i].rel < lo || seen[i].rel > lo + 12) begin
                errors++;
                $display("FAIL random_time%0d: got %0d cycles after release want %0d..%0d",
                         i, seen[i].rel, lo, lo + 12);
            end
        end
    endtask

    initial begin
        test_reset();
        test_letters();
        test_glitch();
        test_word_gap();
        test_reset_mid_letter();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
